score_display: RTL
==================

Name: score_display

Overview:
- Receiving end of the score bus driven by the dino score counter.
- Samples the 15-bit binary score and converts it to 5 BCD digits with a sequential double-dabble engine.
- Drives a time-multiplexed 7-segment display with leading-zero blanking.
- Sits on the display board side, fed directly from the score pins.

Parameters:
SCORE_W, 15, width of binary score input (max 32767 -> 5 digits)
DIGITS, 5, number of BCD digits / display anodes
SCAN_DIV, 1024, clk cycles each digit stays lit (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
score_in  input  SCORE_W  binary score from score counter (may change any cycle)
bcd_out  output  4*DIGITS  converted score, digit 0 in [3:0]
busy  output  1  high while conversion in progress
conv_done  output  1  one-cycle pulse when bcd_out updates
seg  output  7  segments {g,f,e,d,c,b,a}, active-high
an  output  DIGITS  one-hot digit enable, active-high, bit 0 = least significant digit

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high. All outputs registered.
- Reset values:
  - bcd_out=0, busy=0, conv_done=0
  - internal last_score=0, state=IDLE, scan index=0, prescaler=0
  - an=00001, seg=0111111 (digit "0")
- FSM states: IDLE, CONV, LOAD.
- IDLE:
  - If score_in != last_score: capture cap=score_in, shift reg={20'b0, score_in}, bit counter=0, busy<=1, go CONV.
  - Otherwise stay.
- CONV, one bit per cycle:
  - Each BCD nibble >=5 gets +3.
  - Then the whole {bcd, bin} register shifts left by 1.
  - After SCORE_W iterations (counter SCORE_W-1), go LOAD.
- LOAD:
  - bcd_out<=BCD field, last_score<=cap, conv_done<=1 for this cycle only, busy<=0, go IDLE.
- Latency:
  - score_in change sampled at edge N -> bcd_out valid and conv_done high after edge N+SCORE_W+1 (17 cycles for default).
- Mid-conversion changes:
  - score_in changes during CONV/LOAD are ignored.
  - On return to IDLE, mismatch vs last_score is re-detected and a new conversion starts the next cycle.
  - No value is lost except intermediates; the final stable value always converts.
- Back-to-back conversions: minimum IDLE dwell is 1 cycle.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously, independent of FSM.
  - At terminal count the digit index advances, wrapping DIGITS-1 -> 0.
  - an and seg update on the same edge (no ghosting); seg shows digit[index] of bcd_out.
- Seg encoding:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Nibbles >9 (unreachable) show 0000000.
- Leading-zero blanking:
  - Digit k (k>=1) shows seg=0000000 if it and all higher digits are zero.
  - Digit 0 is never blanked; an still asserts for blanked digits.
- Reset mid-CONV:
  - Immediate return to reset values.
  - After release, a nonzero score_in triggers a fresh conversion (last_score=0).
- score_in=0 after reset: no conversion (matches last_score).

Test Plan:
- Reset released with score_in=0 -> bcd_out=0x00000, busy stays 0, no conv_done; with SCAN_DIV=4 digits 1-4 blank, digit 0 seg=0111111.
- score_in=12345 held -> busy high 16 cycles, conv_done pulse at cycle 17, bcd_out=0x12345; scan sweep an=00001..10000 showing 5,4,3,2,1.
- score_in=32767 -> bcd_out=0x32767; score_in=7 next -> bcd_out=0x00007, digits 1-4 seg=0000000, digit 0 seg=0000111.
- score_in 100 -> 250 changed 5 cycles into conversion -> first conv_done gives 0x00100, second conv_done one cycle of IDLE later gives 0x00250.
- rst pulsed mid-CONV with score_in=999 -> outputs return to reset values asynchronously; after release bcd_out=0x00999 17 cycles later.
- SCAN_DIV=4 over 40 cycles -> an one-hot at all times, advances every 4 cycles, wraps 10000->00001, never two bits set.

Source files
------------

// File: rtl/score_display.sv
// Score bus receiver: sequential double-dabble to BCD and a multiplexed 7-segment
// driver with leading-zero blanking. States: IDLE wait for new score | CONV shift one bit | LOAD publish BCD.
module score_display #(
  parameter int SCORE_W  = 15,
  parameter int DIGITS   = 5,
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    score_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  conv_done,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + SCORE_W;
  localparam int CW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   last_q, last_d;
  logic [SCORE_W-1:0]   cap_q, cap_d;
  logic [SW-1:0]        sr_q, sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [6:0]           seg_q, seg_d;
  logic [DIGITS-1:0]    an_q, an_d;

  function automatic logic [SW-1:0] dabble(input logic [SW-1:0] s);
    logic [SW-1:0] t;
    t = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (t[SCORE_W+4*k +: 4] >= 4'd5) t[SCORE_W+4*k +: 4] = t[SCORE_W+4*k +: 4] + 4'd3;
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'd0: r = 7'b0111111;
      4'd1: r = 7'b0000110;
      4'd2: r = 7'b1011011;
      4'd3: r = 7'b1001111;
      4'd4: r = 7'b1100110;
      4'd5: r = 7'b1101101;
      4'd6: r = 7'b1111101;
      4'd7: r = 7'b0000111;
      4'd8: r = 7'b1111111;
      4'd9: r = 7'b1101111;
      default: r = 7'b0000000;
    endcase
    return r;
  endfunction

  // A digit is blank when it and every more significant digit are zero; digit 0 always shows.
  function automatic logic [6:0] digit_seg(input logic [BW-1:0] bcd, input logic [IW-1:0] idx);
    logic [3:0] nib;
    logic       lead;
    nib  = 4'd0;
    lead = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k == int'(idx)) nib = bcd[4*k +: 4];
      if (k >= int'(idx) && bcd[4*k +: 4] != 4'd0) lead = 1'b0;
    end
    if (idx == '0) lead = 1'b0;
    return lead ? 7'b0000000 : seg7(nib);
  endfunction

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cap_d   = cap_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (score_in != last_q) begin
          cap_d   = score_in;
          sr_d    = {{BW{1'b0}}, score_in};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d = dabble(sr_q);
        if (cnt_q == CW'(SCORE_W - 1)) state_d = LOAD;
        else cnt_d = cnt_q + 1'b1;
      end
      LOAD: begin
        bcd_d   = sr_q[SW-1:SCORE_W];
        last_d  = cap_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Scan runs free of the converter; an/seg follow the next index and next BCD together.
    presc_d = (presc_q == PW'(SCAN_DIV - 1)) ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    an_d = '0;
    for (int k = 0; k < DIGITS; k++) an_d[k] = (k == int'(idx_d));
    seg_d = digit_seg(bcd_d, idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      cap_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b0111111;
      an_q    <= {{(DIGITS-1){1'b0}}, 1'b1};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cap_q   <= cap_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign busy      = busy_q;
  assign conv_done = done_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule
